// File: rtl/ternary_pkg.sv
// ternary_pkg: trit encodings, transmitter FSM states, and the elaboration check that TRITS trits cover a WIDTH-bit word
package ternary_pkg;
  localparam logic [1:0] TRIT_0 = 2'b00, TRIT_1 = 2'b01, TRIT_2 = 2'b10, TRIT_BAD = 2'b11;
  typedef enum logic {IDLE, SEND} tx_state_t;
  function automatic bit trits_cover(input int width, input int trits);
    longint p = 1;
    for (int i = 0; i < trits; i++) p = p * 3;
    return p >= (longint'(1) << width);
  endfunction
endpackage

// File: rtl/ternary_word_tx_if.sv
// ternary_word_tx_if: word-in/trit-out handshake bus (in_data/in_valid/in_ready, out1:out0/out_valid/out_ready/out_last); master=source+sink side, slave=transmitter
interface ternary_word_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid, in_ready, out0, out1, out_valid, out_ready, out_last;
  modport master (output in_data, in_valid, out_ready, input in_ready, out0, out1, out_valid, out_last);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out0, out1, out_valid, out_last);
endinterface

// File: rtl/ternary_div3.sv
// ternary_div3: combinational divide by three; x in, q=x/3 and r=x%3 (a trit, never 2'b11) out
module ternary_div3 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       r
);
  assign q = x / WIDTH'(3);
  assign r = 2'(x % WIDTH'(3));
endmodule

// File: rtl/ternary_word_tx.sv
// ternary_word_tx: binary word to LSB-first unsigned trit stream; clk, async active-high rst, bus (slave) carries word input and trit output handshakes
module ternary_word_tx import ternary_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int TRITS = 6
) (
  input logic clk,
  input logic rst,
  ternary_word_tx_if.slave bus
);
  localparam int IW = TRITS > 1 ? $clog2(TRITS) : 1;
  if (!trits_cover(WIDTH, TRITS)) begin : g_bad_trits
    $error("ternary_word_tx: 3**TRITS must be >= 2**WIDTH");
  end
  tx_state_t state, state_n;
  logic [WIDTH-1:0] rem, rem_n, q;
  logic [1:0] trit, trit_n, r;
  logic [IW-1:0] idx, idx_n;
  logic last;
  ternary_div3 #(.WIDTH(WIDTH)) u_div3 (.x(state == IDLE ? bus.in_data : rem), .q(q), .r(r));
  assign last = idx == IW'(TRITS - 1);
  always_comb begin
    state_n = state;
    rem_n = rem;
    trit_n = trit;
    idx_n = idx;
    if (state == IDLE) begin
      if (bus.in_valid) begin
        state_n = SEND;
        rem_n = q;
        trit_n = r;
        idx_n = '0;
      end
    end else if (bus.out_ready) begin
      state_n = last ? IDLE : SEND;
      rem_n = last ? rem : q;
      trit_n = last ? TRIT_0 : r;
      idx_n = last ? idx : idx + IW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      trit <= TRIT_0;
      idx <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      trit <= trit_n;
      idx <= idx_n;
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == SEND;
  assign bus.out_last = state == SEND && last;
  assign {bus.out1, bus.out0} = trit;
endmodule
